wb_dual_master_arbiter: RTL and testbench
=========================================

// Module: wb_dual_master_arbiter
// PURPOSE
//  Two-master, one-slave Wishbone arbiter that shares a single memory slave (data BRAM) between the
//  CPU instruction port (m0) and data port (m1). It sits between the two CPU master ports and one slave port.
//  Round-robin grant, registered grant decision, combinational signal routing once the grant is held.
//  Grant is locked for the whole CYC envelope of the owning master.
// PARAMETERS
//  AW           32    address width
//  DW           32    data width (SEL width = DW/8)
//  TIMEOUT_CYC  255   cycles of STB without ACK before abort (used only with WB_ARB_TIMEOUT_EN)
// PORTS
//  clk_i        in   1      system clock; single clock domain
//  rst_i        in   1      asynchronous, active-low reset
//  m0_cyc_i / m0_stb_i / m0_we_i   in  1 each   master 0 (instruction) cycle, strobe, write enable
//  m0_addr_i / m0_data_i  in  AW / DW   master 0 address and write data
//  m0_sel_i     in   DW/8   master 0 byte select
//  m0_data_o    out  DW     master 0 read data
//  m0_ack_o / m0_err_o    out  1 each   master 0 acknowledge and error
//  m1_*         same as m0_*, for master 1 (data)
//  s_cyc_o / s_stb_o / s_we_o   out  1 each   slave cycle, strobe, write enable
//  s_addr_o / s_data_o / s_sel_o   out  AW / DW / DW/8   slave address, write data, byte select
//  s_data_i     in   DW     slave read data
//  s_ack_i      in   1      slave acknowledge
//  gnt_o        out  2      one-hot current grant {m1,m0}; 00 = idle
// BEHAVIOUR
//  - FSM states: IDLE, GNT0, GNT1. Reset -> IDLE, last_q=1 (m0 wins first tie), gnt_o=00, all s_* = 0.
//  - IDLE: request set req = {m1_cyc_i, m0_cyc_i}.
//    - Only one bit set -> go to that master's grant state.
//    - Both set -> grant the master != last_q.
//    - Transition at the next edge: request in cycle N, slave sees STB in cycle N+1.
//  - GNTx: s_* = mx_* (combinational); mx_data_o = s_data_i; mx_ack_o = s_ack_i.
//    - The non-granted master's ack/err = 0 and its data_o = 0.
//  - GNTx exit: when mx_cyc_i = 0, set last_q = x.
//    - Other master's cyc high -> go directly to GNTy (no idle bubble).
//    - Otherwise -> IDLE.
//  - Grant is held while mx_cyc_i = 1, even if mx_stb_i drops between beats (block/RMW lock).
//  - In IDLE, s_cyc_o = s_stb_o = 0 regardless of requests. A request is never lost; a master waits while the other holds the bus.
//  - s_ack_i arriving in IDLE, or after the owner dropped CYC, is ignored and not forwarded.
//  - Reset mid-transfer: outputs go to 0 immediately (async); the slave sees CYC drop; no ack is forwarded.
// CONFIGURATION
//  - WB_ARB_TIMEOUT_EN defined:
//    - An 8+ bit watchdog counts cycles with s_stb_o=1 and s_ack_i=0; cleared on ack or grant change.
//    - When the count reaches TIMEOUT_CYC: one-cycle mx_err_o=1 to the owner, s_cyc_o/s_stb_o forced 0 that cycle, FSM -> IDLE.
//    - The owner keeps its cycle locked-out until it drops CYC; re-grant only after CYC low once.
//  - WB_ARB_TIMEOUT_EN undefined: no counter, m0_err_o = m1_err_o = 0 constantly, a hung slave hangs the bus.
// STRUCTURE
//  - Shared defines file: FSM encodings ARB_IDLE=2'b00, ARB_GNT0=2'b01, ARB_GNT1=2'b10; default TIMEOUT_CYC.
//  - One sub-module: wb_arb_watchdog (counter + expiry pulse), instantiated only under WB_ARB_TIMEOUT_EN.
//  - Routing mux and FSM stay in this module.
// TESTING
//  1. Reset released, m0 reads 0x0000_0010, slave acks after 2 cycles with 0xDEAD_BEEF
//     -> gnt_o=01 one cycle after CYC; m0_data_o=0xDEAD_BEEF with m0_ack_o; m1_ack_o=0.
//  2. m0 and m1 raise CYC in the same cycle after reset -> m0 granted first; when m0 drops CYC,
//     gnt_o goes 01->10 at the next edge with no IDLE cycle.
//  3. m1 holds CYC over 4 writes (sel=4'b0011) with STB low between beats while m0 requests
//     -> gnt_o stays 10 throughout; s_sel_o=0011 on each beat; m0 granted only after m1 CYC low.
//  4. Both masters request continuously, each doing one-beat cycles, for 10 cycles -> grants alternate 01,10,01,... (round-robin).
//  5. rst_i pulled low while s_stb_o=1 under m1 -> s_cyc_o=0 asynchronously; gnt_o=00; next tie goes to m0.
//  6. WB_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, slave never acks m0
//     -> m0_err_o pulses after 8 STB cycles, s_cyc_o low, FSM IDLE. Without the macro: no err, grant held indefinitely.

Source files
------------

// File: rtl/wb_dual_master_arbiter_pkg.sv
// Shared FSM encodings and constants for the two-master Wishbone arbiter.
// Consumed by wb_dual_master_arbiter and wb_arb_watchdog.
package wb_dual_master_arbiter_pkg;

    // Encodings double as the one-hot grant vector {m1,m0}.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_GNT0 = 2'b01,
        ARB_GNT1 = 2'b10
    } arb_state_e;

    localparam int ARB_TIMEOUT_DEFAULT = 255;

    function automatic int wd_cnt_width(input int timeout_cyc);
        int w;
        w = $clog2(timeout_cyc + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts cycles of an unacknowledged strobe and flags expiry
// once the count reaches TIMEOUT_CYC. Used only when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_watchdog
    import wb_dual_master_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stall_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int            CW    = wd_cnt_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Saturates at LIMIT so a missed clear can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (stall_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LIMIT);

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave between CPU instruction (m0) and data (m1) ports.
// Optional stall watchdog with error abort is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_dual_master_arbiter
    import wb_dual_master_arbiter_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW-1:0]   m0_data_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_data_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m1_data_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_data_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_addr_o,
    output logic [DW-1:0]   s_data_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic [DW-1:0]   s_data_i,
    input  logic            s_ack_i,
    output logic [1:0]      gnt_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_q;
    logic       last_d;
    logic [1:0] lock;
    logic [1:0] req;
    logic       expire;

`ifdef WB_ARB_TIMEOUT_EN
    logic [1:0] lock_q;
    logic [1:0] lock_d;
    logic       stall;
    logic       wd_clear;

    assign stall = ((state_q == ARB_GNT0) && m0_cyc_i && m0_stb_i ||
                    (state_q == ARB_GNT1) && m1_cyc_i && m1_stb_i) && !s_ack_i;
    assign wd_clear = s_ack_i || (state_d != state_q);

    wb_arb_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stall_i (stall),
        .clear_i (wd_clear),
        .expire_o(expire)
    );

    // An aborted master stays locked out until it has dropped CYC at least once.
    always_comb begin
        lock_d = lock_q & {m1_cyc_i, m0_cyc_i};
        if (expire && (state_q == ARB_GNT0)) lock_d[0] = 1'b1;
        if (expire && (state_q == ARB_GNT1)) lock_d[1] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lock_q <= 2'b00;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign lock = lock_q;
`else
    logic unused_timeout;

    assign lock           = 2'b00;
    assign expire         = 1'b0;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

    assign req = {m1_cyc_i & ~lock[1], m0_cyc_i & ~lock[0]};

    // last_q remembers the most recently served master; reset value lets m0 win the first tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (req == 2'b11)  state_d = last_q ? ARB_GNT0 : ARB_GNT1;
                else if (req[0])   state_d = ARB_GNT0;
                else if (req[1])   state_d = ARB_GNT1;
            end
            ARB_GNT0: begin
                if (expire) begin
                    state_d = ARB_IDLE;
                    last_d  = 1'b0;
                end else if (!m0_cyc_i) begin
                    state_d = req[1] ? ARB_GNT1 : ARB_IDLE;
                    last_d  = 1'b0;
                end
            end
            ARB_GNT1: begin
                if (expire) begin
                    state_d = ARB_IDLE;
                    last_d  = 1'b1;
                end else if (!m1_cyc_i) begin
                    state_d = req[0] ? ARB_GNT0 : ARB_IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Acks are qualified with the owner's CYC so a late slave ack after release is dropped.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_data_o  = '0;
        s_sel_o   = '0;
        m0_data_o = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_data_o = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        case (state_q)
            ARB_GNT0: begin
                s_cyc_o   = m0_cyc_i & ~expire;
                s_stb_o   = m0_cyc_i & m0_stb_i & ~expire;
                s_we_o    = m0_we_i;
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
                s_sel_o   = m0_sel_i;
                m0_data_o = s_data_i;
                m0_ack_o  = s_ack_i & m0_cyc_i & ~expire;
                m0_err_o  = expire;
            end
            ARB_GNT1: begin
                s_cyc_o   = m1_cyc_i & ~expire;
                s_stb_o   = m1_cyc_i & m1_stb_i & ~expire;
                s_we_o    = m1_we_i;
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
                s_sel_o   = m1_sel_i;
                m1_data_o = s_data_i;
                m1_ack_o  = s_ack_i & m1_cyc_i & ~expire;
                m1_err_o  = expire;
            end
            default: ;
        endcase
    end

    assign gnt_o = state_q;

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Scenario bench for wb_dual_master_arbiter; the timeout scenario follows WB_ARB_TIMEOUT_EN.
// Acked read data is matched against a queue of {ack0, ack1, data} entries pushed at request time.
module tb_wb_dual_master_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk_i;
    logic          rst_i;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_addr_i;
    logic [DW-1:0] m0_data_i;
    logic [3:0]    m0_sel_i;
    logic [DW-1:0] m0_data_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_data_i;
    logic [3:0]    m1_sel_i;
    logic [DW-1:0] m1_data_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_data_o;
    logic [3:0]    s_sel_o;
    logic [DW-1:0] s_data_i;
    logic          s_ack_i;
    logic [1:0]    gnt_o;

    int          checks = 0;
    int          errors = 0;
    logic [33:0] sb_q[$];
    logic [33:0] sb_e;
    logic [33:0] sb_obs;

    wb_dual_master_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drop_all();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0;
        s_ack_i  = 0; s_data_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1;
        m0_addr_i = 32'h1234; m1_addr_i = 32'h5678; m0_sel_i = 4'hF;
        repeat (3) tick();
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
        checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin errors++; $display("FAIL reset_sctl: got %b want 000", {s_cyc_o, s_stb_o, s_we_o}); end
        checks++; if (s_addr_o !== 32'h0 || s_sel_o !== 4'h0) begin errors++; $display("FAIL reset_saddr: got %h/%h want 0/0", s_addr_o, s_sel_o); end
        checks++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) begin errors++; $display("FAIL reset_acks: got %b want 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); end
        drop_all();
        rst_i = 1;
        tick();
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_release_gnt: got %b want 00", gnt_o); end
    endtask

    task automatic test_single_read();
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_addr_i = 32'h0000_0010; m0_sel_i = 4'hF;
        sb_q.push_back({2'b10, 32'hDEAD_BEEF});
        #1;
        checks++; if (gnt_o !== 2'b00 || s_stb_o !== 1'b0) begin errors++; $display("FAIL rd_req_cycle: gnt %b stb %b want 00/0", gnt_o, s_stb_o); end
        tick();
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rd_gnt: got %b want 01", gnt_o); end
        checks++; if (s_cyc_o !== 1 || s_stb_o !== 1 || s_we_o !== 0 || s_addr_o !== 32'h10) begin errors++; $display("FAIL rd_route: cyc %b stb %b we %b addr %h want 1/1/0/10", s_cyc_o, s_stb_o, s_we_o, s_addr_o); end
        tick();
        tick();
        s_ack_i = 1; s_data_i = 32'hDEAD_BEEF; #1;
        sb_obs = {m0_ack_o, m1_ack_o, m1_ack_o ? m1_data_o : m0_data_o};
        if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL rd_sb: queue empty, got %h", sb_obs); end
        else begin
            sb_e = sb_q.pop_front(); checks++;
            if (sb_obs !== sb_e) begin errors++; $display("FAIL rd_sb: got %h want %h", sb_obs, sb_e); end
        end
        checks++; if (m1_ack_o !== 0 || m1_data_o !== 32'h0 || m0_err_o !== 0) begin errors++; $display("FAIL rd_other: m1_ack %b m1_data %h err %b want 0/0/0", m1_ack_o, m1_data_o, m0_err_o); end
        tick();
        m0_cyc_i = 0; m0_stb_i = 0; #1;
        checks++; if (s_cyc_o !== 0 || m0_ack_o !== 0) begin errors++; $display("FAIL rd_late_ack: cyc %b ack %b want 0/0", s_cyc_o, m0_ack_o); end
        tick();
        checks++; if (gnt_o !== 2'b00 || m0_ack_o !== 0 || m1_ack_o !== 0) begin errors++; $display("FAIL rd_idle_ack: gnt %b acks %b%b want 00/00", gnt_o, m0_ack_o, m1_ack_o); end
        s_ack_i = 0; s_data_i = 0;
    endtask

    task automatic test_tie();
        rst_i = 0; tick(); rst_i = 1; tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h20;
        m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h40;
        sb_q.push_back({2'b10, 32'h1111_0000});
        sb_q.push_back({2'b01, 32'h2222_0000});
        tick();
        checks++; if (gnt_o !== 2'b01 || s_addr_o !== 32'h20) begin errors++; $display("FAIL tie_first: gnt %b addr %h want 01/20", gnt_o, s_addr_o); end
        s_ack_i = 1; s_data_i = 32'h1111_0000; #1;
        sb_obs = {m0_ack_o, m1_ack_o, m1_ack_o ? m1_data_o : m0_data_o};
        if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL tie_sb0: queue empty, got %h", sb_obs); end
        else begin
            sb_e = sb_q.pop_front(); checks++;
            if (sb_obs !== sb_e) begin errors++; $display("FAIL tie_sb0: got %h want %h", sb_obs, sb_e); end
        end
        checks++; if (m1_data_o !== 32'h0) begin errors++; $display("FAIL tie_m1_data: got %h want 0", m1_data_o); end
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL tie_drop_cycle: got %b want 01", gnt_o); end
        tick();
        checks++; if (gnt_o !== 2'b10 || s_stb_o !== 1 || s_addr_o !== 32'h40) begin errors++; $display("FAIL tie_handover: gnt %b stb %b addr %h want 10/1/40", gnt_o, s_stb_o, s_addr_o); end
        s_ack_i = 1; s_data_i = 32'h2222_0000; #1;
        sb_obs = {m0_ack_o, m1_ack_o, m1_ack_o ? m1_data_o : m0_data_o};
        if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL tie_sb1: queue empty, got %h", sb_obs); end
        else begin
            sb_e = sb_q.pop_front(); checks++;
            if (sb_obs !== sb_e) begin errors++; $display("FAIL tie_sb1: got %h want %h", sb_obs, sb_e); end
        end
        checks++; if (m0_data_o !== 32'h0) begin errors++; $display("FAIL tie_m0_data: got %h want 0", m0_data_o); end
        tick();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL tie_idle: got %b want 00", gnt_o); end
    endtask

    task automatic test_lock();
        tick();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'b0011;
        m1_addr_i = 32'h100; m1_data_i = 32'hA000_0000;
        tick();
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL lock_gnt: got %b want 10", gnt_o); end
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_addr_i = 32'h200; m0_sel_i = 4'hF;
        sb_q.push_back({2'b10, 32'h3333_0000});
        for (int b = 0; b < 4; b++) begin
            #1;
            checks++;
            if (s_stb_o !== 1 || s_we_o !== 1 || s_sel_o !== 4'b0011 ||
                s_addr_o !== 32'h100 + 32'(4 * b) || s_data_o !== 32'hA000_0000 + 32'(b)) begin
                errors++; $display("FAIL lock_beat%0d: stb %b we %b sel %b addr %h data %h", b, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o);
            end
            s_ack_i = 1; #1;
            checks++; if (m1_ack_o !== 1 || m0_ack_o !== 0 || gnt_o !== 2'b10) begin errors++; $display("FAIL lock_ack%0d: m1 %b m0 %b gnt %b want 1/0/10", b, m1_ack_o, m0_ack_o, gnt_o); end
            tick();
            s_ack_i = 0; m1_stb_i = 0; #1;
            checks++; if (gnt_o !== 2'b10 || s_stb_o !== 0 || s_cyc_o !== 1) begin errors++; $display("FAIL lock_gap%0d: gnt %b stb %b cyc %b want 10/0/1", b, gnt_o, s_stb_o, s_cyc_o); end
            tick();
            if (b < 3) begin
                m1_stb_i = 1; m1_addr_i = 32'h100 + 32'(4 * (b + 1)); m1_data_i = 32'hA000_0000 + 32'(b + 1);
            end
        end
        m1_cyc_i = 0; m1_we_i = 0; m1_sel_i = 0; #1;
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL lock_release_cycle: got %b want 10", gnt_o); end
        tick();
        checks++; if (gnt_o !== 2'b01 || s_addr_o !== 32'h200) begin errors++; $display("FAIL lock_m0_after: gnt %b addr %h want 01/200", gnt_o, s_addr_o); end
        s_ack_i = 1; s_data_i = 32'h3333_0000; #1;
        sb_obs = {m0_ack_o, m1_ack_o, m1_ack_o ? m1_data_o : m0_data_o};
        if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL lock_sb: queue empty, got %h", sb_obs); end
        else begin
            sb_e = sb_q.pop_front(); checks++;
            if (sb_obs !== sb_e) begin errors++; $display("FAIL lock_sb: got %h want %h", sb_obs, sb_e); end
        end
        tick();
        drop_all();
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h300;
        m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h400;
        exp_gnt = 2'b10;
        tick();
        for (int k = 0; k < 10; k++) begin
            checks++; if (gnt_o !== exp_gnt) begin errors++; $display("FAIL rr_gnt%0d: got %b want %b", k, gnt_o, exp_gnt); end
            sb_q.push_back({exp_gnt[0], exp_gnt[1], 32'h5000_0000 + 32'(k)});
            s_ack_i = 1; s_data_i = 32'h5000_0000 + 32'(k); #1;
            sb_obs = {m0_ack_o, m1_ack_o, m1_ack_o ? m1_data_o : m0_data_o};
            if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL rr_sb%0d: queue empty, got %h", k, sb_obs); end
            else begin
                sb_e = sb_q.pop_front(); checks++;
                if (sb_obs !== sb_e) begin errors++; $display("FAIL rr_sb%0d: got %h want %h", k, sb_obs, sb_e); end
            end
            tick();
            s_ack_i = 0;
            if (exp_gnt[0]) begin m0_cyc_i = 0; m0_stb_i = 0; end
            else begin m1_cyc_i = 0; m1_stb_i = 0; end
            #1;
            checks++; if (gnt_o !== exp_gnt) begin errors++; $display("FAIL rr_hold%0d: got %b want %b", k, gnt_o, exp_gnt); end
            tick();
            m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
            exp_gnt = {exp_gnt[0], exp_gnt[1]};
        end
        drop_all();
        tick();
        tick();
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL rr_idle: got %b want 00", gnt_o); end
    endtask

    task automatic test_reset_mid();
        tick();
        m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h500;
        tick();
        checks++; if (gnt_o !== 2'b10 || s_stb_o !== 1) begin errors++; $display("FAIL rst_mid_pre: gnt %b stb %b want 10/1", gnt_o, s_stb_o); end
        #2;
        rst_i = 0; s_ack_i = 1; #1;
        checks++; if (s_cyc_o !== 0 || s_stb_o !== 0 || gnt_o !== 2'b00 || m1_ack_o !== 0) begin errors++; $display("FAIL rst_mid_async: cyc %b stb %b gnt %b ack %b want 0/0/00/0", s_cyc_o, s_stb_o, gnt_o, m1_ack_o); end
        tick();
        rst_i = 1; s_ack_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h600; #1;
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL rst_mid_release: got %b want 00", gnt_o); end
        tick();
        checks++; if (gnt_o !== 2'b01 || s_addr_o !== 32'h600) begin errors++; $display("FAIL rst_mid_tie: gnt %b addr %h want 01/600", gnt_o, s_addr_o); end
        drop_all();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h700;
        tick();
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL tmo_gnt: got %b want 01", gnt_o); end
`ifdef WB_ARB_TIMEOUT_EN
        n = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            #1;
            if (m0_err_o === 1'b1) seen = 1;
            else begin n++; tick(); end
        end
        checks++; if (!seen || n != TMO) begin errors++; $display("FAIL tmo_count: seen %0d after %0d cycles want 1 after %0d", seen, n, TMO); end
        checks++; if (s_cyc_o !== 0 || s_stb_o !== 0 || m1_err_o !== 0 || m0_ack_o !== 0) begin errors++; $display("FAIL tmo_abort: cyc %b stb %b m1_err %b ack %b want 0/0/0/0", s_cyc_o, s_stb_o, m1_err_o, m0_ack_o); end
        tick();
        checks++; if (gnt_o !== 2'b00 || m0_err_o !== 0) begin errors++; $display("FAIL tmo_idle: gnt %b err %b want 00/0", gnt_o, m0_err_o); end
        repeat (3) tick();
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL tmo_lockout: got %b want 00", gnt_o); end
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL tmo_regrant: got %b want 01", gnt_o); end
`else
        n = 0; seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (m0_err_o !== 0 || m1_err_o !== 0 || gnt_o !== 2'b01 || s_stb_o !== 1) begin
                errors++; $display("FAIL hang_hold%0d: err %b%b gnt %b stb %b want 00/01/1", i, m0_err_o, m1_err_o, gnt_o, s_stb_o);
            end
        end
`endif
        drop_all();
        tick();
        tick();
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL tmo_end_idle: got %b want 00", gnt_o); end
    endtask

    initial begin
        rst_i = 0;
        m0_addr_i = 0; m0_data_i = 0; m1_addr_i = 0; m1_data_i = 0;
        drop_all();
        test_reset();
        test_single_read();
        test_tie();
        test_lock();
        test_round_robin();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t", $time);
        $fatal(1, "bench time limit exceeded");
    end

endmodule
